// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding unit, operand muxes, ALU control and ALU,
// with results captured into the EX/MEM pipeline register.
module ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_id_ex_data_1,
   input  logic [DATA_W-1:0] i_id_ex_data_2,
   input  logic [REG_W-1:0]  i_id_ex_rs,
   input  logic [REG_W-1:0]  i_id_ex_rt,
   input  logic [REG_W-1:0]  i_id_ex_rd,
   input  logic [4:0]        i_id_ex_shamt,
   input  logic [DATA_W-1:0] i_id_ex_extended_beq_offset,
   input  logic              i_id_ex_alu_src,
   input  logic              i_id_ex_reg_dst,
   input  logic [3:0]        i_id_ex_alu_op,
   input  logic [5:0]        i_id_ex_function_code,
   input  logic              i_id_ex_reg_write,
   input  logic              i_id_ex_mem_read,
   input  logic              i_id_ex_mem_write,
   input  logic              i_id_ex_mem_to_reg,
   input  logic [REG_W-1:0]  i_ex_m_rd,
   input  logic [REG_W-1:0]  i_m_wb_rd,
   input  logic              i_ex_m_reg_write,
   input  logic              i_m_wb_reg_write,
   input  logic [DATA_W-1:0] i_ex_m_alu_result,
   input  logic [DATA_W-1:0] i_m_wb_data_write,
   output logic [1:0]        o_forward_a,
   output logic [1:0]        o_forward_b,
   output logic [DATA_W-1:0] o_ex_m_alu_result,
   output logic [DATA_W-1:0] o_ex_m_data_2,
   output logic [REG_W-1:0]  o_ex_m_rd,
   output logic              o_ex_m_reg_write,
   output logic              o_ex_m_mem_read,
   output logic              o_ex_m_mem_write,
   output logic              o_ex_m_mem_to_reg
);

   typedef enum logic [5:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLLV, ALU_SRLV, ALU_SRAV, ALU_LUI, ALU_ZERO
   } alu_ctl_e;

   alu_ctl_e          alu_ctl;
   logic [1:0]        forward_a, forward_b;
   logic [DATA_W-1:0] op_a, fwd_rt, op_b, result;
   logic [REG_W-1:0]  dest;

   // EX/MEM match is tested first so it wins over a concurrent MEM/WB match
   always_comb begin
      forward_a = 2'b00;
      forward_b = 2'b00;
      if (i_ex_m_reg_write && i_ex_m_rd != '0 && i_ex_m_rd == i_id_ex_rs)
         forward_a = 2'b01;
      else if (i_m_wb_reg_write && i_m_wb_rd != '0 && i_m_wb_rd == i_id_ex_rs)
         forward_a = 2'b10;
      if (i_ex_m_reg_write && i_ex_m_rd != '0 && i_ex_m_rd == i_id_ex_rt)
         forward_b = 2'b01;
      else if (i_m_wb_reg_write && i_m_wb_rd != '0 && i_m_wb_rd == i_id_ex_rt)
         forward_b = 2'b10;
   end

   assign o_forward_a = forward_a;
   assign o_forward_b = forward_b;

   always_comb begin
      case (forward_a)
         2'b01:   op_a = i_ex_m_alu_result;
         2'b10:   op_a = i_m_wb_data_write;
         default: op_a = i_id_ex_data_1;
      endcase
      case (forward_b)
         2'b01:   fwd_rt = i_ex_m_alu_result;
         2'b10:   fwd_rt = i_m_wb_data_write;
         default: fwd_rt = i_id_ex_data_2;
      endcase
      op_b = i_id_ex_alu_src ? i_id_ex_extended_beq_offset : fwd_rt;
      dest = i_id_ex_reg_dst ? i_id_ex_rd : i_id_ex_rt;
   end

   always_comb begin
      alu_ctl = ALU_ADD;
      case (i_id_ex_alu_op)
         4'b0000: alu_ctl = ALU_ADD;
         4'b0001: alu_ctl = ALU_SUB;
         4'b0010: begin
            case (i_id_ex_function_code)
               6'b100000, 6'b100001: alu_ctl = ALU_ADD;
               6'b100010, 6'b100011: alu_ctl = ALU_SUB;
               6'b100100: alu_ctl = ALU_AND;
               6'b100101: alu_ctl = ALU_OR;
               6'b100110: alu_ctl = ALU_XOR;
               6'b100111: alu_ctl = ALU_NOR;
               6'b101010: alu_ctl = ALU_SLT;
               6'b101011: alu_ctl = ALU_SLTU;
               6'b000000: alu_ctl = ALU_SLL;
               6'b000010: alu_ctl = ALU_SRL;
               6'b000011: alu_ctl = ALU_SRA;
               6'b000100: alu_ctl = ALU_SLLV;
               6'b000110: alu_ctl = ALU_SRLV;
               6'b000111: alu_ctl = ALU_SRAV;
               default:   alu_ctl = ALU_ZERO;
            endcase
         end
         4'b0011: alu_ctl = ALU_AND;
         4'b0100: alu_ctl = ALU_OR;
         4'b0101: alu_ctl = ALU_XOR;
         4'b0110: alu_ctl = ALU_LUI;
         4'b0111: alu_ctl = ALU_SLT;
         4'b1000: alu_ctl = ALU_SLTU;
         default: alu_ctl = ALU_ADD;
      endcase
   end

   always_comb begin
      result = '0;
      case (alu_ctl)
         ALU_ADD:  result = op_a + op_b;
         ALU_SUB:  result = op_a - op_b;
         ALU_AND:  result = op_a & op_b;
         ALU_OR:   result = op_a | op_b;
         ALU_XOR:  result = op_a ^ op_b;
         ALU_NOR:  result = ~(op_a | op_b);
         ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
         ALU_SLL:  result = op_b << i_id_ex_shamt;
         ALU_SRL:  result = op_b >> i_id_ex_shamt;
         ALU_SRA:  result = $signed(op_b) >>> i_id_ex_shamt;
         ALU_SLLV: result = op_b << op_a[4:0];
         ALU_SRLV: result = op_b >> op_a[4:0];
         ALU_SRAV: result = $signed(op_b) >>> op_a[4:0];
         ALU_LUI:  result = op_b << 16;
         default:  result = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_ex_m_alu_result <= '0;
         o_ex_m_data_2     <= '0;
         o_ex_m_rd         <= '0;
         o_ex_m_reg_write  <= 1'b0;
         o_ex_m_mem_read   <= 1'b0;
         o_ex_m_mem_write  <= 1'b0;
         o_ex_m_mem_to_reg <= 1'b0;
      end else begin
         o_ex_m_alu_result <= result;
         o_ex_m_data_2     <= fwd_rt;
         o_ex_m_rd         <= dest;
         o_ex_m_reg_write  <= i_id_ex_reg_write;
         o_ex_m_mem_read   <= i_id_ex_mem_read;
         o_ex_m_mem_write  <= i_id_ex_mem_write;
         o_ex_m_mem_to_reg <= i_id_ex_mem_to_reg;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a behavioural model
// of forwarding, operand selection and the MIPS ALU.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_1, data_2, imm, exm_res, mwb_data;
   logic [4:0]  rs, rt, rd, shamt, exm_rd, mwb_rd;
   logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
   logic        exm_we, mwb_we;
   logic [3:0]  alu_op;
   logic [5:0]  funct;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] out_res, out_d2;
   logic [4:0]  out_rd;
   logic        out_rw, out_mr, out_mw, out_m2r;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   ex_stage #(.DATA_W(32), .REG_W(5)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_id_ex_data_1(data_1), .i_id_ex_data_2(data_2),
      .i_id_ex_rs(rs), .i_id_ex_rt(rt), .i_id_ex_rd(rd),
      .i_id_ex_shamt(shamt), .i_id_ex_extended_beq_offset(imm),
      .i_id_ex_alu_src(alu_src), .i_id_ex_reg_dst(reg_dst),
      .i_id_ex_alu_op(alu_op), .i_id_ex_function_code(funct),
      .i_id_ex_reg_write(reg_write), .i_id_ex_mem_read(mem_read),
      .i_id_ex_mem_write(mem_write), .i_id_ex_mem_to_reg(mem_to_reg),
      .i_ex_m_rd(exm_rd), .i_m_wb_rd(mwb_rd),
      .i_ex_m_reg_write(exm_we), .i_m_wb_reg_write(mwb_we),
      .i_ex_m_alu_result(exm_res), .i_m_wb_data_write(mwb_data),
      .o_forward_a(fwd_a), .o_forward_b(fwd_b),
      .o_ex_m_alu_result(out_res), .o_ex_m_data_2(out_d2), .o_ex_m_rd(out_rd),
      .o_ex_m_reg_write(out_rw), .o_ex_m_mem_read(out_mr),
      .o_ex_m_mem_write(out_mw), .o_ex_m_mem_to_reg(out_m2r)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Bypassed value of a source register: newest producer wins, $zero never bypasses
   function automatic logic [31:0] src_val(input logic [4:0] r, input logic [31:0] rf);
      if (r != 0 && exm_we && exm_rd == r) return exm_res;
      if (r != 0 && mwb_we && mwb_rd == r) return mwb_data;
      return rf;
   endfunction

   function automatic logic [1:0] src_sel(input logic [4:0] r);
      if (r != 0 && exm_we && exm_rd == r) return 2'd1;
      if (r != 0 && mwb_we && mwb_rd == r) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      case (alu_op)
         4'd1: return a - b;
         4'd2: begin
            case (funct)
               6'h20, 6'h21: return a + b;
               6'h22, 6'h23: return a - b;
               6'h24: return a & b;
               6'h25: return a | b;
               6'h26: return a ^ b;
               6'h27: return ~(a | b);
               6'h2a: return (sa < sb) ? 32'd1 : 32'd0;
               6'h2b: return (a < b) ? 32'd1 : 32'd0;
               6'h00: return 32'(longint'(b) * (longint'(1) << shamt));
               6'h02: return 32'(longint'(b) / (longint'(1) << shamt));
               6'h03: return 32'(sb >>> shamt);
               6'h04: return 32'(longint'(b) * (longint'(1) << a[4:0]));
               6'h06: return 32'(longint'(b) / (longint'(1) << a[4:0]));
               6'h07: return 32'(sb >>> a[4:0]);
               default: return 32'd0;
            endcase
         end
         4'd3: return a & b;
         4'd4: return a | b;
         4'd5: return a ^ b;
         4'd6: return {b[15:0], 16'h0000};
         4'd7: return (sa < sb) ? 32'd1 : 32'd0;
         4'd8: return (a < b) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   // Inputs are stable here; check forwarding now, registered outputs after the edge.
   task automatic step(input string tag);
      logic [31:0] a, rtv, e_res;
      logic [4:0]  e_rd;
      logic [3:0]  e_ctl;
      #1;
      a     = src_val(rs, data_1);
      rtv   = src_val(rt, data_2);
      e_res = ref_alu(a, alu_src ? imm : rtv);
      e_rd  = reg_dst ? rd : rt;
      e_ctl = {reg_write, mem_read, mem_write, mem_to_reg};
      check({tag, ".fwd_a"}, 32'(fwd_a), 32'(src_sel(rs)));
      check({tag, ".fwd_b"}, 32'(fwd_b), 32'(src_sel(rt)));
      @(posedge clk); #1;
      if (reset) begin
         e_res = 0; rtv = 0; e_rd = 0; e_ctl = 0;
      end
      check({tag, ".result"}, out_res, e_res);
      check({tag, ".data_2"}, out_d2, rtv);
      check({tag, ".rd"}, 32'(out_rd), 32'(e_rd));
      check({tag, ".ctl"}, 32'({out_rw, out_mr, out_mw, out_m2r}), 32'(e_ctl));
   endtask

   task automatic clear_inputs();
      data_1 = 0; data_2 = 0; imm = 0; exm_res = 0; mwb_data = 0;
      rs = 0; rt = 0; rd = 0; shamt = 0; exm_rd = 0; mwb_rd = 0;
      alu_src = 0; reg_dst = 0; reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
      exm_we = 0; mwb_we = 0; alu_op = 0; funct = 6'h20;
   endtask

   task automatic randomize_inputs();
      logic [5:0] functs [16];
      functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      data_1 = $urandom; data_2 = $urandom; imm = $urandom;
      exm_res = $urandom; mwb_data = $urandom;
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom); shamt = 5'($urandom);
      exm_rd = 5'($urandom_range(0, 3)); mwb_rd = 5'($urandom_range(0, 3));
      exm_we = 1'($urandom); mwb_we = 1'($urandom);
      alu_src = 1'($urandom); reg_dst = 1'($urandom);
      reg_write = 1'($urandom); mem_read = 1'($urandom);
      mem_write = 1'($urandom); mem_to_reg = 1'($urandom);
      alu_op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd2;
      funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 15)];
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      data_1 = 32'h1111_1111; reg_write = 1; reg_dst = 1; rd = 5'd7;
      step("reset0");
      reset = 0;

      // Bypass from MEM/WB into A, ADD via funct
      clear_inputs();
      rs = 2; rt = 3; rd = 4; mwb_rd = 2; mwb_we = 1; mwb_data = 32'hDEADBEEF;
      data_2 = 3; alu_op = 4'b0010; funct = 6'h20; reg_dst = 1; reg_write = 1;
      step("wb_fwd");
      check("wb_fwd.abs", out_res, 32'hDEADBEF2);

      // Both stages match: EX/MEM wins
      exm_rd = 2; exm_we = 1; exm_res = 32'h12345678;
      step("both_fwd");

      // Writes to $zero never forward
      clear_inputs();
      exm_we = 1; exm_rd = 0; exm_res = 32'hAAAA5555; data_1 = 32'h42; imm = 1; alu_src = 1;
      step("zero_reg");
      check("zero_reg.abs", out_res, 32'h43);

      // Immediate operand with ADD / SLT / SLTU
      clear_inputs();
      alu_src = 1; imm = 32'hFFFFFFFF; data_1 = 5;
      alu_op = 4'b0000; step("imm_add"); check("imm_add.abs", out_res, 32'h4);
      alu_op = 4'b0111; step("imm_slt"); check("imm_slt.abs", out_res, 32'h0);
      alu_op = 4'b1000; step("imm_sltu"); check("imm_sltu.abs", out_res, 32'h1);

      // Shifts by shamt
      clear_inputs();
      alu_op = 4'b0010; shamt = 4; data_2 = 32'h80000000;
      funct = 6'h03; step("sra"); check("sra.abs", out_res, 32'hF8000000);
      funct = 6'h02; step("srl"); check("srl.abs", out_res, 32'h08000000);

      // rs == rt both forwarded from EX/MEM
      clear_inputs();
      rs = 5; rt = 5; exm_rd = 5; exm_we = 1; exm_res = 32'h00000009;
      alu_op = 4'b0010; funct = 6'h22;
      step("same_src"); check("same_src.abs", out_res, 32'h0);

      // Reset mid-stream, then normal capture on the following edge
      clear_inputs();
      data_1 = 32'h100; data_2 = 32'h23; alu_op = 4'b0000;
      reg_write = 1; mem_read = 1; mem_write = 1; mem_to_reg = 1; rt = 9;
      step("pre_rst");
      reset = 1; step("mid_rst");
      reset = 0; step("post_rst");
      check("post_rst.abs", out_res, 32'h123);

      for (int i = 0; i < 300; i++) begin
         randomize_inputs();
         reset = ($urandom_range(0, 39) == 0);
         step("rand");
      end
      reset = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
